// File: rtl/arbiter_pkg.sv
`default_nettype none
// =====================================================================
// Module : arbiter_pkg
// Brief  : Shared state encoding and width helper for the stream mux.
// Rev    : 1.0  initial release
// =====================================================================
package arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Ceiling log2; usable in constant expressions for port/counter widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_stream_mux_rr_pick.sv
`default_nettype none
// =====================================================================
// Module : rr_pick
// Brief  : Round-robin picker; first request strictly above ptr, with wrap.
// Rev    : 1.0  initial release
// =====================================================================
module rr_pick #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   w_above;
  logic [2*N-1:0] w_dbl;

  always_comb begin
    w_above = '0;
    for (int i = 0; i < N; i++) begin
      w_above[i] = (i > int'(ptr));
    end
  end

  // Lower half holds only requests above ptr, so the lowest set bit of the
  // doubled vector is the next owner; the upper half supplies the wrap.
  assign w_dbl = {req, req & w_above};

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!any && w_dbl[j]) begin
        any                          = 1'b1;
        idx                          = IDX_W'((j >= N) ? (j - N) : j);
        pick[(j >= N) ? (j - N) : j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbiter_stream_mux.sv
`default_nettype none
// =====================================================================
// Module : arbiter_stream_mux
// Brief  : Packet-aware N:1 round-robin stream scheduler, registered output.
// Rev    : 1.0  initial release
// =====================================================================
module arbiter_stream_mux
  import arbiter_pkg::*;
#(
  parameter int  NUM_PORTS  = 9,
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_BURST  = 16,
  localparam int PORT_W     = clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]               out_port,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            active
);

  localparam logic [PORT_W-1:0] C_PTR_INIT = PORT_W'(NUM_PORTS - 1);

  state_t                  r_state;
  logic [NUM_PORTS-1:0]    r_grant;
  logic [PORT_W-1:0]       r_ptr;
  logic [NUM_PORTS-1:0]    w_pick;
  logic [PORT_W-1:0]       w_pick_idx;
  logic                    w_any;
  logic                    w_can_load;
  logic                    w_accept;
  logic                    w_sel_last;
  logic                    w_cnt_hit;
  logic                    w_burst_end;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (PORT_W)
  ) u_pick (
    .req  (in_valid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

  // Grant is zero outside BURST, so in_ready is naturally gated by state.
  assign w_can_load  = ~out_valid | out_ready;
  assign in_ready    = r_grant & {NUM_PORTS{w_can_load}};
  assign w_accept    = |(in_valid & in_ready);
  assign w_sel_last  = |(in_last & r_grant);
  assign w_burst_end = w_accept & (w_sel_last | w_cnt_hit);

  always_comb begin
    w_sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant[p]) w_sel_data = w_sel_data | in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  if (MAX_BURST != 0) begin : g_cnt
    localparam int               CNT_W      = clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);
    logic [CNT_W-1:0]            r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_burst_end) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_cnt_hit = (r_cnt == C_CNT_LAST);
  end else begin : g_no_cnt
    assign w_cnt_hit = 1'b0;
  end

  // The pointer doubles as the owner index for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= C_PTR_INIT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BURST;
            r_grant <= w_pick;
            r_ptr   <= w_pick_idx;
          end
        end
        BURST: begin
          if (w_burst_end) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_last  <= w_sel_last;
      out_data  <= w_sel_data;
      out_port  <= r_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign grant  = r_grant;
  assign active = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_arbiter_stream_mux.sv
`default_nettype none
// =====================================================================
// Module : tb_arbiter_stream_mux
// Brief  : Directed bench for arbiter_stream_mux (MAX_BURST 16 and 4).
// Rev    : 1.0  initial release
// =====================================================================
module tb_arbiter_stream_mux;

  localparam int NP = 9;
  localparam int DW = 32;
  localparam int PW = 4;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             out_ready;
  logic [NP-1:0]    src_en;
  int unsigned      pkt_len [NP];
  logic [15:0]      beat_a [NP];
  logic [15:0]      beat_b [NP];

  logic [NP-1:0]    last_a, last_b, ready_a, ready_b, grant_a, grant_b;
  logic [NP*DW-1:0] data_a, data_b;
  logic             ov_a, ol_a, act_a, ov_b, ol_b, act_b;
  logic [DW-1:0]    od_a, od_b;
  logic [PW-1:0]    op_a, op_b;

  beat_t            log_a [$];
  beat_t            log_b [$];
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(src_en), .in_last(last_a), .in_data(data_a),
    .in_ready(ready_a), .out_valid(ov_a), .out_last(ol_a), .out_data(od_a),
    .out_port(op_a), .out_ready(out_ready), .grant(grant_a), .active(act_a)
  );

  arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(src_en), .in_last(last_b), .in_data(data_b),
    .in_ready(ready_b), .out_valid(ov_b), .out_last(ol_b), .out_data(od_b),
    .out_port(op_b), .out_ready(out_ready), .grant(grant_b), .active(act_b)
  );

  function automatic logic [31:0] exp_data(input int p, input int b);
    return {8'(p), 8'h00, 16'(b)};
  endfunction

  // Sources: each port streams numbered beats, packets of pkt_len beats.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      last_a[p]             = ((32'(beat_a[p]) + 1) % pkt_len[p]) == 0;
      last_b[p]             = ((32'(beat_b[p]) + 1) % pkt_len[p]) == 0;
      data_a[p*DW +: DW]    = exp_data(p, int'(beat_a[p]));
      data_b[p*DW +: DW]    = exp_data(p, int'(beat_b[p]));
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!rst) begin
        beat_a[p] <= '0;
        beat_b[p] <= '0;
      end else begin
        if (src_en[p] && ready_a[p]) beat_a[p] <= beat_a[p] + 16'd1;
        if (src_en[p] && ready_b[p]) beat_b[p] <= beat_b[p] + 16'd1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && ov_a && out_ready) log_a.push_back('{int'(op_a), od_a, ol_a, cyc});
    if (rst && ov_b && out_ready) log_b.push_back('{int'(op_b), od_b, ol_b, cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input bit use_b, input int idx,
                          input int port, input int beat, input logic last);
    beat_t e;
    bit    ok;
    ok = use_b ? (idx < log_b.size()) : (idx < log_a.size());
    check({tag, "_present"}, 64'(ok), 64'(1));
    if (ok) begin
      e = use_b ? log_b[idx] : log_a[idx];
      check({tag, "_port"}, 64'(e.port), 64'(port));
      check({tag, "_data"}, 64'(e.data), 64'(exp_data(port, beat)));
      check({tag, "_last"}, 64'(e.last), 64'(last));
    end
  endtask

  task automatic wait_beats(input bit use_b, input int n);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((use_b ? log_b.size() : log_a.size()) >= n) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("wait_beats", 64'(reached), 64'(1));
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [NP-1:0] en, input int len);
    @(negedge clk);
    rst    = 1'b0;
    src_en = '0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < NP; p++) pkt_len[p] = len;
    src_en = en;
    rst    = 1'b1;
  endtask

  initial begin
    int    s;
    logic [DW-1:0] held;

    rst       = 1'b0;
    out_ready = 1'b1;
    src_en    = '1;
    for (int p = 0; p < NP; p++) pkt_len[p] = 1;

    // Reset held with every port requesting.
    repeat (10) @(negedge clk);
    check("rst_grant", 64'(grant_a), 64'(0));
    check("rst_valid", 64'(ov_a), 64'(0));
    check("rst_ready", 64'(ready_a), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("first_grant", 64'(grant_a), 64'h001);
    check("first_active", 64'(act_a), 64'(1));
    check("first_no_beat", 64'(ov_a), 64'(0));

    // All ports valid, single-beat packets: 0..8 then wrap to 0.
    wait_beats(1'b0, 10);
    for (int p = 0; p < NP; p++) chk_beat($sformatf("all_p%0d", p), 1'b0, p, p, 0, 1'b1);
    chk_beat("all_wrap", 1'b0, 9, 0, 1, 1'b1);

    // Rotation between ports 0 and 8.
    do_reset(9'b100000001, 1);
    s = log_a.size();
    wait_beats(1'b0, s + 4);
    chk_beat("rot0", 1'b0, s + 0, 0, 0, 1'b1);
    chk_beat("rot1", 1'b0, s + 1, 8, 0, 1'b1);
    chk_beat("rot2", 1'b0, s + 2, 0, 1, 1'b1);
    chk_beat("rot3", 1'b0, s + 3, 8, 1, 1'b1);

    // Burst lock: port1 5-beat packet while port2 waits.
    do_reset(9'b000000110, 5);
    s = log_a.size();
    wait_beats(1'b0, s + 6);
    for (int b = 0; b < 5; b++) chk_beat($sformatf("lock_b%0d", b), 1'b0, s + b, 1, b, b == 4);
    chk_beat("lock_next", 1'b0, s + 5, 2, 0, 1'b0);
    if (log_a.size() >= s + 6) begin
      check("lock_span", 64'(log_a[s+4].cyc - log_a[s].cyc), 64'(4));
      check("lock_idle_gap", 64'(log_a[s+5].cyc - log_a[s+4].cyc), 64'(2));
    end

    // MAX_BURST=4 truncation of a 10-beat packet.
    do_reset(9'b001100000, 10);
    s = log_b.size();
    wait_beats(1'b1, s + 9);
    for (int b = 0; b < 4; b++) chk_beat($sformatf("trunc_p5_b%0d", b), 1'b1, s + b, 5, b, 1'b0);
    chk_beat("trunc_p6", 1'b1, s + 4, 6, 0, 1'b0);
    chk_beat("trunc_p5_resume", 1'b1, s + 8, 5, 4, 1'b0);

    // Backpressure mid-burst.
    do_reset(9'b000001000, 8);
    s = log_a.size();
    wait_beats(1'b0, s + 3);
    out_ready = 1'b0;
    #1;
    held = od_a;
    check("bp_valid", 64'(ov_a), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), 64'(od_a), 64'(held));
      check($sformatf("bp_ready%0d", i), 64'(ready_a), 64'(0));
    end
    out_ready = 1'b1;
    wait_beats(1'b0, s + 8);
    for (int b = 0; b < 8; b++) chk_beat($sformatf("bp_b%0d", b), 1'b0, s + b, 3, b, b == 7);

    // Asynchronous reset in the middle of a burst.
    do_reset(9'b000010000, 8);
    s = log_a.size();
    wait_beats(1'b0, s + 2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("areset_grant", 64'(grant_a), 64'(0));
    check("areset_active", 64'(act_a), 64'(0));
    check("areset_valid", 64'(ov_a), 64'(0));
    check("areset_data", 64'(od_a), 64'(0));
    check("areset_port", 64'(op_a), 64'(0));
    check("areset_last", 64'(ol_a), 64'(0));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
